// File: rtl/hid_gamepad_decoder_if.sv
// Report input strobe and event output stream shared between the USB host
// side and the decoder.
interface hid_gamepad_decoder_if #(
  parameter int C_report_bytes = 8
);
  logic [C_report_bytes*8-1:0] hid_report;
  logic                        hid_valid;
  logic                        ev_valid;
  logic [4:0]                  ev_data;
  logic                        ev_ready;

  modport master (output hid_report, hid_valid, ev_ready, input ev_valid, ev_data);
  modport slave  (input hid_report, hid_valid, ev_ready, output ev_valid, ev_data);
endinterface

// File: rtl/hid_gamepad_decoder.sv
// HID gamepad report decoder: registered axes/buttons, presence timeout and a
// FIFO of per-button press/release events derived by a 16-cycle bit scan.
module hid_gamepad_decoder #(
  parameter int C_report_bytes   = 8,
  parameter int C_timeout_cycles = 6000000,
  parameter int C_event_depth    = 8
)(
  input  logic                   clk_i,
  input  logic                   rstn_i,
  hid_gamepad_decoder_if.slave   bus,
  output logic [7:0]             axis_x,
  output logic [7:0]             axis_y,
  output logic [15:0]            buttons,
  output logic                   changed,
  output logic                   connected,
  output logic [15:0]            report_count,
  output logic [7:0]             overrun_count
);
  localparam int TW = $clog2(C_timeout_cycles + 1);
  localparam int AW = $clog2(C_event_depth);
  localparam logic [TW-1:0] TMO_LAST = TW'(C_timeout_cycles - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(C_event_depth);

  typedef enum logic {IDLE, SCAN} state_e;

  logic [7:0]  axis_x_q, axis_y_q, overrun_count_q;
  logic [15:0] buttons_q, report_count_q;
  logic        changed_q, connected_q;
  logic [TW-1:0] tmo_q;

  logic [7:0]  new_x, new_y;
  logic [15:0] new_btn;
  logic        timeout_hit, overrun;
  logic        unused_report_bits;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] diff_q, diff_d, target_q, target_d, baseline_q, baseline_d;
  logic [15:0] pending_q, pending_d;
  logic        pv_q, pv_d;
  logic        push, pop, full;
  logic [4:0]  push_data;

  logic [4:0]    mem_q [C_event_depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  assign new_x   = bus.hid_report[31:24];
  assign new_y   = bus.hid_report[39:32];
  assign new_btn = bus.hid_report[55:40];
  assign unused_report_bits = ^bus.hid_report;

  // A report arriving in the timeout cycle keeps the device connected.
  assign timeout_hit = connected_q && !bus.hid_valid && (tmo_q == TMO_LAST);
  assign overrun     = bus.hid_valid && pv_q && (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      axis_x_q        <= '0;
      axis_y_q        <= '0;
      buttons_q       <= '0;
      changed_q       <= 1'b0;
      connected_q     <= 1'b0;
      report_count_q  <= '0;
      overrun_count_q <= '0;
      tmo_q           <= '0;
    end else begin
      changed_q <= 1'b0;
      if (bus.hid_valid) begin
        axis_x_q       <= new_x;
        axis_y_q       <= new_y;
        buttons_q      <= new_btn;
        changed_q      <= {axis_x_q, axis_y_q, buttons_q} != {new_x, new_y, new_btn};
        report_count_q <= report_count_q + 16'd1;
        connected_q    <= 1'b1;
        tmo_q          <= '0;
        if (overrun && overrun_count_q != 8'hFF)
          overrun_count_q <= overrun_count_q + 8'd1;
      end else if (connected_q) begin
        if (timeout_hit) begin
          connected_q <= 1'b0;
          axis_x_q    <= '0;
          axis_y_q    <= '0;
          buttons_q   <= '0;
          changed_q   <= |{axis_x_q, axis_y_q, buttons_q};
          tmo_q       <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      diff_q     <= '0;
      target_q   <= '0;
      baseline_q <= '0;
      pending_q  <= '0;
      pv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      diff_q     <= diff_d;
      target_q   <= target_d;
      baseline_q <= baseline_d;
      pending_q  <= pending_d;
      pv_q       <= pv_d;
    end
  end

  assign push_data = {target_q[idx_q], idx_q};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    diff_d     = diff_q;
    target_d   = target_q;
    baseline_d = baseline_q;
    pending_d  = pending_q;
    pv_d       = pv_q;
    push       = 1'b0;
    case (state_q)
      IDLE: if (pv_q) begin
        diff_d   = pending_q ^ baseline_q;
        target_d = pending_q;
        pv_d     = 1'b0;
        idx_d    = '0;
        state_d  = SCAN;
      end
      SCAN: if (!diff_q[idx_q] || !full) begin
        // baseline tracks exactly what has been pushed, so a later scan
        // always converges on the final button state.
        if (diff_q[idx_q]) begin
          push              = 1'b1;
          baseline_d[idx_q] = target_q[idx_q];
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.hid_valid) begin
      pending_d = new_btn;
      pv_d      = 1'b1;
    end else if (timeout_hit) begin
      pending_d = '0;
      pv_d      = 1'b1;
    end
  end

  // Full uses registered occupancy: a same-cycle pop does not free a slot.
  assign full = (cnt_q == DEPTH);
  assign pop  = (cnt_q != '0) && bus.ev_ready;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.ev_valid  = (cnt_q != '0);
  assign bus.ev_data   = mem_q[rd_ptr_q];
  assign axis_x        = axis_x_q;
  assign axis_y        = axis_y_q;
  assign buttons       = buttons_q;
  assign changed       = changed_q;
  assign connected     = connected_q;
  assign report_count  = report_count_q;
  assign overrun_count = overrun_count_q;
endmodule

// File: doc/hid_gamepad_decoder.md
# hid_gamepad_decoder

Consumes raw HID reports from `usbh_host_hid` (`hid_report`/`hid_valid`, clk_usb domain) and turns them into registered gamepad state plus a queued stream of per-button press/release events. It sits between the USB host core and downstream consumers such as the display-latch or game logic. It also provides a device-presence flag, based on a report timeout, and report/overrun counters.

## Interface
- `C_report_bytes`, default 8: report width in bytes; must be ≥ 7.
- `C_timeout_cycles`, default 6000000: idle cycles without `hid_valid` before disconnect (1 s at 6 MHz).
- `C_event_depth`, default 8: event FIFO depth; power of two, ≥ 2.
- `clk_i`  in  1: single clock (clk_usb). Everything is rising-edge.
- `rstn_i`  in  1: reset, asynchronous, active-low.
- `hid_report`  in  C_report_bytes*8: report; byte k = bits [8k+7:8k].
- `hid_valid`  in  1: single-cycle strobe; `hid_report` is valid in that cycle.
- `axis_x`  out  8: byte 3 of the last report.
- `axis_y`  out  8: byte 4 of the last report.
- `buttons`  out  16: {byte 6, byte 5} of the last report; 1 = pressed.
- `changed`  out  1: one-cycle pulse when `axis_x`, `axis_y` or `buttons` change value.
- `connected`  out  1: device presence.
- `ev_valid`  out  1: event FIFO is non-empty.
- `ev_data`  out  5: {press, index[3:0]}, head of the FIFO.
- `ev_ready`  in  1: consumer pop.
- `report_count`  out  16: number of accepted reports, wraps at 16 bits.
- `overrun_count`  out  8: number of pending reports overwritten; saturates at 255.

## Operation
- **Reset values:** all outputs 0; FIFO empty; `baseline` = 0; `pending_valid` = 0; FSM in IDLE; timeout counter 0.
- **Capture on `hid_valid`:**
  - `axis_x`, `axis_y` and `buttons` are registered from the report.
  - `changed` = 1 if any of those three differs from its previous value.
  - `report_count` increments.
  - `connected` is set to 1.
  - The timeout counter clears.
  - `pending` ← new buttons; `pending_valid` ← 1.
  - If `pending_valid` was already 1 and the FSM had not yet loaded it, the latest report wins and `overrun_count` increments, saturating.
- **Timeout:**
  - While `connected` = 1 and no `hid_valid` arrives, the counter increments each cycle.
  - When the count reaches `C_timeout_cycles` − 1: `connected` ← 0, `buttons`/`axis_x`/`axis_y` ← 0, `changed` pulses if any of them was non-zero, and `pending` ← 0 with `pending_valid` ← 1. This produces release events for every held button.
  - The counter is idle while disconnected.
  - If `hid_valid` arrives in the same cycle as the timeout, `hid_valid` wins.
- **Event FSM, state IDLE:**
  - If `pending_valid` = 1: `diff` ← `pending` ^ `baseline`, `target` ← `pending`, `pending_valid` ← 0, `idx` ← 0, go to SCAN.
  - A `hid_valid` arriving in that same cycle sets `pending_valid` again. This is not an overrun.
- **Event FSM, state SCAN, per cycle for bit `idx`:**
  - If `diff[idx]` = 0: advance `idx`.
  - If `diff[idx]` = 1 and the FIFO is not full: push {`target[idx]`, `idx`}, set `baseline[idx]` ← `target[idx]`, advance `idx`.
  - If `diff[idx]` = 1 and the FIFO is full: stall and hold `idx`.
  - After `idx` = 15 is processed, go to IDLE.
  - Events within one scan come out in ascending index order.
- **Consistency rule:** `baseline` always equals the button state implied by all events pushed so far. Intermediate states lost to overwrite never produce events, but the final state is always reached.
- **FIFO:**
  - First-word-fall-through; `ev_data` is valid whenever `ev_valid` = 1.
  - Pop when `ev_valid` & `ev_ready`.
  - Full is computed from registered occupancy, so a push is refused in a full cycle even if a pop happens in that cycle.
  - A simultaneous push and pop while not full or empty leaves occupancy unchanged.

## Timing
- `hid_valid` at cycle t → `buttons`/`axes`/`changed`/`report_count`/`connected` update at t+1.
- `pending_valid` is visible at t+1. With the FSM idle: it is loaded at t+1, SCAN runs t+2..t+17, and IDLE is reached at t+18.
- An event pushed in cycle c is visible on `ev_valid`/`ev_data` at c+1.
- A scan takes at least 16 cycles, plus one cycle per full-FIFO stall.
- `rstn_i` asserted mid-scan: immediate return to reset values; queued events are discarded.

## Test plan
- **Reset:** assert `rstn_i` = 0 during activity → all outputs 0, `ev_valid` = 0 while it is held low and on release.
- **Single report:** bytes 5,6 = 0x05,0x80, byte 3 = 0x7F, `ev_ready` = 1 → at t+1 `buttons` = 0x8005, `axis_x` = 0x7F, `changed` = 1. Events {1,0}, {1,2}, {1,15} appear in that order, the last on `ev_valid` by t+18.
- **Back-to-back overwrite:** three reports with buttons 0x0001, 0x0002, 0x0003, spaced 2 cycles apart → `overrun_count` = 1. Events: {1,0} from the first scan, then {1,1} only. Final `baseline` = 0x0003.
- **Backpressure:** `ev_ready` = 0, report with `buttons` = 0xFFFF, depth 8 → 8 events queued, FSM stalls at `idx` = 8. Releasing `ev_ready` delivers all 16 events in order with no loss or duplication.
- **Timeout:** `C_timeout_cycles` = 100, `buttons` = 0x0011, then silence → `connected` falls exactly 100 cycles after the last capture. `buttons` = 0, `changed` pulses, and events {0,0}, {0,4} follow.
- **Identical report and collision:** a repeat of the same report → `changed` = 0, no events, `report_count` increments. `hid_valid` in the timeout cycle → `connected` stays 1.
